// File: rtl/alsu_cmd_issuer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alsu_cmd_issuer_if
//  Purpose  : Bundles the tagged command handshake, the ALSU drive and
//             result buses, and the response port of alsu_cmd_issuer.
//             master = environment side, slave = the issuer itself.
//  Revision : 1.0  initial release
// ============================================================================
interface alsu_cmd_issuer_if #(
  parameter int TAG_W = 4
) ();
  // command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_A;
  logic [2:0]       cmd_B;
  logic [2:0]       cmd_opcode;
  logic             cmd_cin;
  logic             cmd_serial_in;
  logic             cmd_direction;
  logic             cmd_red_op_A;
  logic             cmd_red_op_B;
  logic             cmd_bypass_A;
  logic             cmd_bypass_B;
  logic [TAG_W-1:0] cmd_tag;

  // drive into the ALSU and its result bus
  logic [2:0]       alsu_A;
  logic [2:0]       alsu_B;
  logic [2:0]       alsu_opcode;
  logic             alsu_cin;
  logic             alsu_serial_in;
  logic             alsu_direction;
  logic             alsu_red_op_A;
  logic             alsu_red_op_B;
  logic             alsu_bypass_A;
  logic             alsu_bypass_B;
  logic [5:0]       alsu_out;

  // response channel
  logic             rsp_valid;
  logic [5:0]       rsp_out;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_invalid;
  logic [7:0]       err_cnt;

  modport master (
    output cmd_valid, cmd_A, cmd_B, cmd_opcode, cmd_cin, cmd_serial_in,
           cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A,
           cmd_bypass_B, cmd_tag, alsu_out,
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
           alsu_bypass_B, rsp_valid, rsp_out, rsp_tag, rsp_invalid, err_cnt
  );

  modport slave (
    input  cmd_valid, cmd_A, cmd_B, cmd_opcode, cmd_cin, cmd_serial_in,
           cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A,
           cmd_bypass_B, cmd_tag, alsu_out,
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
           alsu_bypass_B, rsp_valid, rsp_out, rsp_tag, rsp_invalid, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/alsu_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alsu_cmd_issuer
//  Purpose  : Buffers tagged ALSU commands in a small FIFO, issues one per
//             cycle onto registered ALSU inputs (all-zero no-op when idle),
//             tracks the ALSU's 2-cycle latency and returns each captured
//             result with its tag, an invalid flag and a saturating error
//             count.
//  Revision : 1.0  initial release
// ============================================================================
module alsu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input wire               clk,
  input wire               rst_n,
  alsu_cmd_issuer_if.slave bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  typedef struct packed {
    logic [2:0]       a;
    logic [2:0]       b;
    logic [2:0]       opcode;
    logic             cin;
    logic             serial_in;
    logic             direction;
    logic             red_op_a;
    logic             red_op_b;
    logic             bypass_a;
    logic             bypass_b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Opcodes 110/111, or a reduction request on anything but OR/XOR.
  function automatic logic classify_invalid(input entry_t e);
    return (e.opcode[1] & e.opcode[2]) |
           ((e.red_op_a | e.red_op_b) & (e.opcode[1] | e.opcode[2]));
  endfunction

  // FIFO state
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cmd_ready_q, cmd_ready_d;

  // Issue register: what the ALSU sees this cycle
  entry_t             iss_q, iss_d;
  logic               iss_inv_q, iss_inv_d;

  // Result tracking pipeline; the rsp_* registers form its last stage
  logic               s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s1_inv_q, s1_inv_d;
  logic               s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;
  logic               s2_inv_q, s2_inv_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [5:0]         rsp_out_q, rsp_out_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_inv_q, rsp_inv_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               push;
  logic               pop;
  entry_t             cmd_entry;
  entry_t             head_next;

  // FIFO bookkeeping and selection of the entry to present next cycle
  always_comb begin
    push                = bus.cmd_valid && cmd_ready_q;
    pop                 = (count_q != '0);
    cmd_entry           = '0;
    cmd_entry.a         = bus.cmd_A;
    cmd_entry.b         = bus.cmd_B;
    cmd_entry.opcode    = bus.cmd_opcode;
    cmd_entry.cin       = bus.cmd_cin;
    cmd_entry.serial_in = bus.cmd_serial_in;
    cmd_entry.direction = bus.cmd_direction;
    cmd_entry.red_op_a  = bus.cmd_red_op_A;
    cmd_entry.red_op_b  = bus.cmd_red_op_B;
    cmd_entry.bypass_a  = bus.cmd_bypass_A;
    cmd_entry.bypass_b  = bus.cmd_bypass_B;
    cmd_entry.tag       = bus.cmd_tag;
    rd_ptr_d            = rd_ptr_q;
    wr_ptr_d            = wr_ptr_q;
    count_d             = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = cmd_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // The new head is the entry being written only when the older entries
    // are exhausted; the issue register is loaded one cycle ahead so the
    // head appears on alsu_* in the cycle it is popped.
    head_next = (push && (wr_ptr_q == rd_ptr_d)) ? cmd_entry : mem_q[rd_ptr_d];
    if (count_d != '0) begin
      iss_d     = head_next;
      iss_inv_d = classify_invalid(head_next);
    end else begin
      iss_d     = '0;
      iss_inv_d = 1'b0;
    end
    cmd_ready_d = (count_d != FULL_CNT);
  end

  // Latency tracking, result capture and error counting
  always_comb begin
    s1_valid_d  = pop;
    s1_tag_d    = iss_q.tag;
    s1_inv_d    = iss_inv_q;
    s2_valid_d  = s1_valid_q;
    s2_tag_d    = s1_tag_q;
    s2_inv_d    = s1_inv_q;
    rsp_valid_d = s2_valid_q;
    rsp_out_d   = bus.alsu_out;
    rsp_tag_d   = s2_tag_q;
    rsp_inv_d   = s2_inv_q;
    err_cnt_d   = err_cnt_q;
    if (s2_valid_q && s2_inv_q && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers; reset discards queued and in-flight commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      iss_q       <= '0;
      iss_inv_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_inv_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_inv_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_inv_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      iss_q       <= iss_d;
      iss_inv_q   <= iss_inv_d;
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_inv_q    <= s1_inv_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_inv_q    <= s2_inv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_inv_q   <= rsp_inv_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.alsu_A         = iss_q.a;
  assign bus.alsu_B         = iss_q.b;
  assign bus.alsu_opcode    = iss_q.opcode;
  assign bus.alsu_cin       = iss_q.cin;
  assign bus.alsu_serial_in = iss_q.serial_in;
  assign bus.alsu_direction = iss_q.direction;
  assign bus.alsu_red_op_A  = iss_q.red_op_a;
  assign bus.alsu_red_op_B  = iss_q.red_op_b;
  assign bus.alsu_bypass_A  = iss_q.bypass_a;
  assign bus.alsu_bypass_B  = iss_q.bypass_b;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_out        = rsp_out_q;
  assign bus.rsp_tag        = rsp_tag_q;
  assign bus.rsp_invalid    = rsp_inv_q;
  assign bus.err_cnt        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alsu_cmd_issuer
//  Purpose  : Scoreboard bench for alsu_cmd_issuer with a cycle model of the
//             downstream ALSU and a queue-server reference of the issuer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alsu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [2:0]       a;
    logic [2:0]       b;
    logic [2:0]       op;
    logic             cin;
    logic             si;
    logic             dir;
    logic             ra;
    logic             rb;
    logic             ba;
    logic             bb;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct {
    logic [5:0]       out;
    logic [TAG_W-1:0] tag;
    logic             inv;
    int               due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alsu_cmd_issuer_if #(.TAG_W(TAG_W)) bus ();
  alsu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   last_issue = -100;
  logic [5:0] last_out = '0;
  int   exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALSU behaviour ----------------
  function automatic logic is_invalid(input cmd_t c);
    return (c.op >= 3'd6) || ((c.ra || c.rb) && (c.op >= 3'd2));
  endfunction

  function automatic logic [5:0] alsu_f(input cmd_t c, input logic [5:0] prev);
    int sa;
    int sb_v;
    sa   = $signed(c.a);
    sb_v = $signed(c.b);
    if (is_invalid(c)) return 6'd0;
    if (c.ba) return 6'(sa);
    if (c.bb) return 6'(sb_v);
    case (c.op)
      3'd0: begin
        if (c.ra) return {5'd0, |c.a};
        if (c.rb) return {5'd0, |c.b};
        return 6'(sa | sb_v);
      end
      3'd1: begin
        if (c.ra) return {5'd0, ^c.a};
        if (c.rb) return {5'd0, ^c.b};
        return 6'(sa ^ sb_v);
      end
      3'd2: return 6'(sa + sb_v + int'(c.cin));
      3'd3: return 6'(sa * sb_v);
      3'd4: return c.dir ? {prev[4:0], c.si} : {c.si, prev[5:1]};
      3'd5: return c.dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  // Downstream ALSU: registered inputs then registered output, reset by !rst_n.
  cmd_t       drive_c;
  cmd_t       alsu_in_r;
  logic [5:0] alsu_out_r;
  always_comb begin
    drive_c     = '0;
    drive_c.a   = bus.alsu_A;
    drive_c.b   = bus.alsu_B;
    drive_c.op  = bus.alsu_opcode;
    drive_c.cin = bus.alsu_cin;
    drive_c.si  = bus.alsu_serial_in;
    drive_c.dir = bus.alsu_direction;
    drive_c.ra  = bus.alsu_red_op_A;
    drive_c.rb  = bus.alsu_red_op_B;
    drive_c.ba  = bus.alsu_bypass_A;
    drive_c.bb  = bus.alsu_bypass_B;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alsu_in_r  <= '0;
      alsu_out_r <= '0;
    end else begin
      alsu_in_r  <= drive_c;
      alsu_out_r <= alsu_f(alsu_in_r, alsu_out_r);
    end
  end
  assign bus.alsu_out = alsu_out_r;

  // ---------------- reference model ----------------
  // Single-server queue: an entry accepted in cycle k issues at the later of
  // k+1 and one cycle after the previous issue; a gap means the ALSU saw a
  // no-op and its out register is 0.
  task automatic model_accept(input cmd_t c, input int k);
    int         issue;
    logic [5:0] prev;
    exp_t       e;
    issue    = (k + 1 > last_issue + 1) ? k + 1 : last_issue + 1;
    prev     = (issue == last_issue + 1) ? last_out : 6'd0;
    e.out    = alsu_f(c, prev);
    e.tag    = c.tag;
    e.inv    = is_invalid(c);
    e.due    = issue + 3;
    sb.push_back(e);
    last_issue = issue;
    last_out   = e.out;
  endtask

  task automatic model_reset();
    sb.delete();
    last_issue = -100;
    last_out   = '0;
    exp_err    = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got tag %0d expected no response (cycle %0d)",
                   bus.rsp_tag, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_out", int'(bus.rsp_out), int'(e.out));
          chk("rsp_tag", int'(bus.rsp_tag), int'(e.tag));
          chk("rsp_invalid", int'(bus.rsp_invalid), int'(e.inv));
          chk("rsp_cycle", cyc, e.due);
          if (e.inv && exp_err < 255) exp_err++;
          chk("err_cnt", int'(bus.err_cnt), exp_err);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp: got none expected tag %0d due cycle %0d (cycle %0d)",
                 sb[0].tag, sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input cmd_t c, input bit must_accept);
    int waited;
    bit done;
    waited            = 0;
    done              = 1'b0;
    bus.cmd_valid     = 1'b1;
    bus.cmd_A         = c.a;
    bus.cmd_B         = c.b;
    bus.cmd_opcode    = c.op;
    bus.cmd_cin       = c.cin;
    bus.cmd_serial_in = c.si;
    bus.cmd_direction = c.dir;
    bus.cmd_red_op_A  = c.ra;
    bus.cmd_red_op_B  = c.rb;
    bus.cmd_bypass_A  = c.ba;
    bus.cmd_bypass_B  = c.bb;
    bus.cmd_tag       = c.tag;
    while (!done) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        model_accept(c, cyc);
        done = 1'b1;
      end else begin
        if (must_accept) chk("cmd_ready_held", 0, 1);
        waited++;
        if (waited > 50) begin
          chk("accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] op, input logic [TAG_W-1:0] tag);
    cmd_t c;
    c     = '0;
    c.a   = a;
    c.b   = b;
    c.op  = op;
    c.tag = tag;
    return c;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    bus.cmd_valid = 1'b0;
    bus.cmd_A = '0; bus.cmd_B = '0; bus.cmd_opcode = '0; bus.cmd_cin = 1'b0;
    bus.cmd_serial_in = 1'b0; bus.cmd_direction = 1'b0; bus.cmd_red_op_A = 1'b0;
    bus.cmd_red_op_B = 1'b0; bus.cmd_bypass_A = 1'b0; bus.cmd_bypass_B = 1'b0;
    bus.cmd_tag = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", int'(bus.cmd_ready), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_err_cnt", int'(bus.err_cnt), 0);
    chk("reset_alsu_opcode", int'(bus.alsu_opcode), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_cmd_ready", int'(bus.cmd_ready), 1);
    @(posedge clk); #1;

    // ADD 3+2+1 and MULT -2*3
    c = mk(3'd3, 3'd2, 3'b010, 4'd5); c.cin = 1'b1;
    send(c, 1'b1);
    idle(6);
    send(mk(3'b110, 3'd3, 3'b011, 4'd7), 1'b1);
    idle(6);

    // six back-to-back commands, tags 0..5
    for (int i = 0; i < 6; i++) begin
      send(mk(3'(i), 3'(i + 1), 3'b010, 4'(i)), 1'b1);
    end
    drain();

    // invalid opcodes, then saturate err_cnt
    send(mk(3'd1, 3'd1, 3'b110, 4'd8), 1'b1);
    c = mk(3'd1, 3'd1, 3'b010, 4'd9); c.ra = 1'b1;
    send(c, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send(mk(3'(i), 3'(i >> 3), ((i % 2) == 0) ? 3'b110 : 3'b111, 4'(i)), 1'b1);
    end
    drain();
    chk("err_cnt_saturated", int'(bus.err_cnt), 255);

    // shift chain back-to-back, then with an idle cycle in between
    c = mk(3'b101, 3'd0, 3'b000, 4'd1); c.ba = 1'b1;
    send(c, 1'b1);
    c = mk(3'd0, 3'd0, 3'b100, 4'd2); c.dir = 1'b1; c.si = 1'b0;
    send(c, 1'b1);
    idle(6);
    c = mk(3'b101, 3'd0, 3'b000, 4'd3); c.ba = 1'b1;
    send(c, 1'b1);
    idle(1);
    c = mk(3'd0, 3'd0, 3'b100, 4'd4); c.dir = 1'b1; c.si = 1'b0;
    send(c, 1'b1);
    drain();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      c     = '0;
      c.a   = 3'($urandom);
      c.b   = 3'($urandom);
      c.op  = 3'($urandom_range(0, 7));
      c.cin = 1'($urandom);
      c.si  = 1'($urandom);
      c.dir = 1'($urandom);
      c.ra  = ($urandom_range(0, 5) == 0);
      c.rb  = ($urandom_range(0, 5) == 0);
      c.ba  = ($urandom_range(0, 7) == 0);
      c.bb  = ($urandom_range(0, 7) == 0);
      c.tag = 4'($urandom);
      send(c, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // reset with three commands in flight
    send(mk(3'd1, 3'd1, 3'b110, 4'd10), 1'b1);
    send(mk(3'd2, 3'd1, 3'b010, 4'd11), 1'b1);
    send(mk(3'd3, 3'd1, 3'b010, 4'd12), 1'b1);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_err_cnt", int'(bus.err_cnt), 0);
    chk("midreset_rsp_valid", int'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    send(mk(3'd2, 3'd2, 3'b010, 4'd13), 1'b0);
    drain();
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
